// File: rtl/axis_packet_switch.sv
// axis_packet_switch
// Routes one of NUM_IN AXI-Stream slaves to any subset of NUM_OUT masters.
// The route is taken from cfg_* while idle and is frozen from the first beat of
// a multi-beat packet until the beat carrying tlast[0]. Accepted beats go through
// a 2-entry buffer. The head entry is offered to every output in its mask, and
// each output completes exactly once. The head retires when the last masked
// output has taken it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_in_sel            0 / >NUM_IN = no input, k = input k-1
//   cfg_out_mask          destination mask (multi-hot allowed, 0 = drop)
//   s_user                sideband, stored with each accepted beat
//   s_tdata/s_tlast       packed input lanes, lane i at [i*W +: W]
//   s_tvalid/s_tready     per-input handshake
//   m_tdata/m_tlast/m_tuser  shared output payload (head entry)
//   m_tvalid/m_tready     per-output handshake
//   in_beat, pkt_done, drop_beat  single-cycle event pulses
//   busy                  packet locked or buffer not empty
//
// state | meaning
// IDLE  | route follows cfg_* live, no packet in progress
// LOCK  | multi-beat packet in progress, route frozen until tlast[0]
module axis_packet_switch #(
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 9,
  parameter int DATA_W  = 1536,
  parameter int LAST_W  = 12,
  parameter int USER_W  = 1,
  localparam int SEL_W  = $clog2(NUM_IN + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL_W-1:0]           cfg_in_sel,
  input  logic [NUM_OUT-1:0]         cfg_out_mask,
  input  logic [USER_W-1:0]          s_user,
  input  logic [NUM_IN*DATA_W-1:0]   s_tdata,
  input  logic [NUM_IN*LAST_W-1:0]   s_tlast,
  input  logic [NUM_IN-1:0]          s_tvalid,
  output logic [NUM_IN-1:0]          s_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic [LAST_W-1:0]          m_tlast,
  output logic [USER_W-1:0]          m_tuser,
  output logic [NUM_OUT-1:0]         m_tvalid,
  input  logic [NUM_OUT-1:0]         m_tready,
  output logic                       in_beat,
  output logic                       pkt_done,
  output logic                       drop_beat,
  output logic                       busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]         r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [NUM_OUT-1:0] r_mask;
  // Holds s_tready low for the first cycle after reset release so nothing is
  // accepted while reset is still being removed.
  logic               r_run;

  logic [DATA_W-1:0]  r_data  [2];
  logic [LAST_W-1:0]  r_last  [2];
  logic [USER_W-1:0]  r_user  [2];
  logic [NUM_OUT-1:0] r_emask [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic [NUM_OUT-1:0] r_sent;

  logic [SEL_W-1:0]   w_sel;
  logic [NUM_OUT-1:0] w_mask;
  logic [NUM_IN-1:0]  w_sready;
  logic [DATA_W-1:0]  w_in_data;
  logic [LAST_W-1:0]  w_in_last;
  logic               w_head_vld;
  logic [NUM_OUT-1:0] w_head_mask;
  logic [NUM_OUT-1:0] w_mvalid;
  logic [NUM_OUT-1:0] w_hs;
  logic               w_pop;
  logic               w_space;
  logic               w_accept;
  logic               w_push;

  assign w_sel  = (r_state == ST_LOCK) ? r_sel  : cfg_in_sel;
  assign w_mask = (r_state == ST_LOCK) ? r_mask : cfg_out_mask;

  assign w_head_vld  = (r_count != 2'd0);
  assign w_head_mask = r_emask[r_rd_ptr];
  assign w_mvalid    = {NUM_OUT{w_head_vld}} & w_head_mask & ~r_sent;
  assign w_hs        = w_mvalid & m_tready;
  // Retire once every masked output has either completed earlier or completes now.
  assign w_pop       = w_head_vld & ((r_sent | w_hs) == w_head_mask);
  // A full buffer still takes a beat when the head leaves in the same cycle.
  assign w_space     = (r_count != 2'd2) | w_pop;

  always_comb begin
    w_sready  = '0;
    w_in_data = '0;
    w_in_last = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_sel == SEL_W'(i + 1)) begin
        w_sready[i] = r_run & w_space;
        w_in_data   = s_tdata[i*DATA_W +: DATA_W];
        w_in_last   = s_tlast[i*LAST_W +: LAST_W];
      end
    end
  end

  assign w_accept = |(s_tvalid & w_sready);
  assign w_push   = w_accept & (|w_mask);

  assign s_tready  = w_sready;
  assign m_tvalid  = w_mvalid;
  assign m_tdata   = r_data[r_rd_ptr];
  assign m_tlast   = r_last[r_rd_ptr];
  assign m_tuser   = r_user[r_rd_ptr];
  assign in_beat   = w_accept;
  assign drop_beat = w_accept & ~(|w_mask);
  assign pkt_done  = w_pop & r_last[r_rd_ptr][0];
  assign busy      = (r_state == ST_LOCK) | w_head_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_mask     <= '0;
      r_run      <= 1'b0;
      r_data[0]  <= '0;
      r_data[1]  <= '0;
      r_last[0]  <= '0;
      r_last[1]  <= '0;
      r_user[0]  <= '0;
      r_user[1]  <= '0;
      r_emask[0] <= '0;
      r_emask[1] <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_sent     <= '0;
    end else begin
      r_run <= 1'b1;

      if (w_push) begin
        r_data[r_wr_ptr]  <= w_in_data;
        r_last[r_wr_ptr]  <= w_in_last;
        r_user[r_wr_ptr]  <= s_user;
        r_emask[r_wr_ptr] <= w_mask;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      r_sent <= w_pop ? '0 : (r_sent | w_hs);

      if (w_accept) begin
        if ((r_state == ST_IDLE) && !w_in_last[0]) begin
          r_state <= ST_LOCK;
          r_sel   <= cfg_in_sel;
          r_mask  <= cfg_out_mask;
        end else if ((r_state == ST_LOCK) && w_in_last[0]) begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

endmodule
